// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding and stream framing constants.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_SHIFT     = 2;

endpackage

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid pulses for one cycle after the 4th byte.
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (byte_valid) begin
      if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
        word_d  = {shift_q, byte_data};
        valid_d = 1'b1;
        cnt_d   = 2'd0;
      end else begin
        shift_d = {shift_q[15:0], byte_data};
        cnt_d   = cnt_q + 2'd1;
      end
    end
    // An abort drops any partially gathered word and any pending write.
    if (clear) begin
      cnt_d   = 2'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a 16-bit word-count header, writes the byte stream as words into instruction memory.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_SIZE  = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reload,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CHECK;
  logic [7:0] sum_q, sum_d;
`else
  localparam state_t POST_DATA = RUN;
`endif

  state_t      state_q, state_d;
  logic [7:0]  n_hi_q, n_hi_d;
  logic [15:0] n_q, n_d;
  logic [15:0] k_q, k_d;
  logic [31:0] word;
  logic        word_valid;
  logic        last_word_wr;
  logic        xfer;
  logic        byte_take;

  // While the final word is being written the image is complete, so no further byte is taken in DATA.
  assign last_word_wr = word_valid && (k_q == n_q - 16'd1);

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, CHECK: in_ready = 1'b1;
      DATA:                  in_ready = ~last_word_wr;
      default:               in_ready = 1'b0;
    endcase
    if (reload) in_ready = 1'b0;
  end

  assign xfer      = in_valid & in_ready;
  assign byte_take = xfer && (state_q == DATA);

  byte_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (reload),
    .byte_valid (byte_take),
    .byte_data  (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  assign mem_we     = word_valid & ~reload;
  assign mem_wdata  = word;
  assign mem_addr   = BASE_ADDR + ({16'd0, k_q} << WORD_SHIFT);
  assign cpu_stall  = (state_q != RUN);
  assign load_done  = (state_q == RUN);
  assign load_error = (state_q == ERROR);

  always_comb begin
    state_d = state_q;
    n_hi_d  = n_hi_q;
    n_d     = n_q;
    k_d     = k_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    if (byte_take) sum_d = sum_q + in_data;
`endif
    case (state_q)
      HDR_HI: begin
        if (xfer) begin
          n_hi_d  = in_data;
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          n_d = {n_hi_q, in_data};
          if (n_d == 16'd0)                state_d = POST_DATA;
          else if (n_d > 16'(MEM_SIZE))    state_d = ERROR;
          else                             state_d = DATA;
        end
      end
      DATA: begin
        if (mem_we) begin
          k_d = k_q + 16'd1;
          if (last_word_wr) state_d = POST_DATA;
        end
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer) state_d = (in_data == sum_q) ? RUN : ERROR;
`endif
      end
      default: state_d = state_q;
    endcase
    if (reload) begin
      state_d = HDR_HI;
      k_d     = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = 8'd0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= HDR_HI;
      n_hi_q  <= 8'd0;
      n_q     <= 16'd0;
      k_q     <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      n_hi_q  <= n_hi_d;
      n_q     <= n_d;
      k_q     <= k_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; also covers the IMEM_LOADER_CHECKSUM_EN build.
module tb_imem_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reload = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        load_done;
  logic        load_error;

  int passes = 0;
  int total  = 0;
  int wr_cnt = 0;
  int base   = 0;
  logic [31:0] wr_addr [0:31];
  logic [31:0] wr_data [0:31];

  imem_boot_loader #(.MEM_SIZE(128), .BASE_ADDR(32'h0)) dut (
    .clock      (clock),
    .reset      (reset),
    .reload     (reload),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset && mem_we && wr_cnt < 32) begin
      wr_addr[wr_cnt] <= mem_addr;
      wr_data[wr_cnt] <= mem_wdata;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
  endtask

  task automatic pulse_reload();
    in_valid = 1'b0;
    reload   = 1'b1;
    step();
    reload   = 1'b0;
    #1;
  endtask

  initial begin
    // Reset
    step();
    step();
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_error", load_error, 0);
    reset = 1'b1;
    step();

    // 1: two-word image, bytes every cycle
    base = wr_cnt;
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'h01); send(8'h09); send(8'h50); send(8'h20);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t1_we2", mem_we, 1);
    chk("t1_addr2", mem_addr, 32'h4);
    chk("t1_data2", mem_wdata, 32'h01095020);
    chk("t1_not_done_yet", load_done, 0);
    step();
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t1_check_ready", in_ready, 1);
    chk("t1_check_not_done", load_done, 0);
    send(8'hA7);
    in_valid = 1'b0;
    #1;
`endif
    chk("t1_done", load_done, 1);
    chk("t1_stall", cpu_stall, 0);
    chk("t1_ready_run", in_ready, 0);
    chk("t1_nwrites", wr_cnt - base, 2);
    chk("t1_w0_addr", wr_addr[base], 32'h0);
    chk("t1_w0_data", wr_data[base], 32'h20080005);
    chk("t1_w1_addr", wr_addr[base+1], 32'h4);
    chk("t1_w1_data", wr_data[base+1], 32'h01095020);

    // 2: zero-length image
    pulse_reload();
    chk("t2_reload_ready", in_ready, 1);
    chk("t2_reload_done", load_done, 0);
    base = wr_cnt;
    send(8'h00); send(8'h00);
    in_valid = 1'b0;
    #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t2_check_not_done", load_done, 0);
    send(8'h00);
    in_valid = 1'b0;
    #1;
`endif
    chk("t2_done", load_done, 1);
    step(); step();
    chk("t2_nwrites", wr_cnt - base, 0);

    // 3: oversized header
    pulse_reload();
    base = wr_cnt;
    send(8'h00); send(8'h81);
    in_valid = 1'b0;
    #1;
    chk("t3_error", load_error, 1);
    chk("t3_ready", in_ready, 0);
    chk("t3_stall", cpu_stall, 1);
    step();
    chk("t3_still_error", load_error, 1);
    chk("t3_nwrites", wr_cnt - base, 0);
    pulse_reload();
    chk("t3_reload_ready", in_ready, 1);
    chk("t3_reload_error", load_error, 0);

    // 4: one-word image with in_valid toggling
    base = wr_cnt;
    send(8'h00); in_valid = 1'b0; step();
    send(8'h01); in_valid = 1'b0; step();
    send(8'hDE); in_valid = 1'b0; step();
    send(8'hAD); in_valid = 1'b0; step();
    send(8'hBE); in_valid = 1'b0; step();
    send(8'hEF);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t4_we", mem_we, 1);
    chk("t4_addr", mem_addr, 32'h0);
    chk("t4_data", mem_wdata, 32'hDEADBEEF);
    step();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h38);
    in_valid = 1'b0;
    #1;
`endif
    chk("t4_done", load_done, 1);
    chk("t4_nwrites", wr_cnt - base, 1);

    // 5: reload coinciding with the 3rd data byte
    pulse_reload();
    send(8'h00); send(8'h01); send(8'h11); send(8'h22);
    in_valid = 1'b1;
    in_data  = 8'h33;
    reload   = 1'b1;
    #1;
    chk("t5_ready_on_reload", in_ready, 0);
    step();
    reload   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t5_ready_after", in_ready, 1);
    chk("t5_stall_after", cpu_stall, 1);
    base = wr_cnt;
    send(8'h00); send(8'h01);
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t5_we", mem_we, 1);
    chk("t5_addr", mem_addr, 32'h0);
    chk("t5_data", mem_wdata, 32'hA1B2C3D4);
    step();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'hEA);
    in_valid = 1'b0;
    #1;
`endif
    chk("t5_done", load_done, 1);
    chk("t5_nwrites", wr_cnt - base, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    pulse_reload();
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    in_valid = 1'b0;
    step();
    send(8'h0A);
    in_valid = 1'b0;
    #1;
    chk("t6_good_done", load_done, 1);
    chk("t6_good_error", load_error, 0);
    pulse_reload();
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    in_valid = 1'b0;
    step();
    send(8'h0B);
    in_valid = 1'b0;
    #1;
    chk("t6_bad_error", load_error, 1);
    chk("t6_bad_stall", cpu_stall, 1);
    chk("t6_bad_done", load_done, 0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
